delay_meas_ctrl: RTL

Propagation-delay measurement controller for the gate-level cell models (inverter, NAND/NOR, buffer and flip-flop chains). It sequences a single device under test (DUT) through four phases: preset, settle, launch and measure. It then reports, in whole clock cycles, how long the DUT output takes to respond to a stimulus edge, or flags a timeout. It sits between the bench or host sequencer and one DUT instance, and owns that DUT's input pin for the duration of a measurement.

---
 rtl/delay_meas_pkg.sv | 18 +
 rtl/delay_meas_ctrl_sync2.sv | 21 ++
 rtl/delay_meas_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/delay_meas_pkg.sv
// Shared types and defaults for the propagation-delay measurement controller.
// SYNC_STAGES is the depth of the optional dut_y synchronizer (DELAY_MEAS_SYNC_EN).
package delay_meas_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESET,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  localparam int CNT_W_DEF   = 8;
  localparam int SETTLE_DEF  = 4;
  localparam int TIMEOUT_DEF = 200;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/delay_meas_ctrl_sync2.sv
// Two-flop synchronizer for the observed DUT output, synchronous active-high reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/delay_meas_ctrl.sv
// Propagation-delay measurement controller: preset, settle, launch, measure one DUT.
// Define DELAY_MEAS_SYNC_EN to synchronize dut_y; the added latency is subtracted from results.
module delay_meas_ctrl
  import delay_meas_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SETTLE  = SETTLE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             launch_edge,
  input  logic             dut_y,
  output logic             dut_a,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] delay_cyc,
  output logic             timeout
);

  logic y_obs;

`ifdef DELAY_MEAS_SYNC_EN
  localparam int COMP = SYNC_STAGES;

  sync2 u_sync (
    .clk (C),
    .rst (R),
    .d   (dut_y),
    .q   (y_obs)
  );
`else
  localparam int COMP = 0;

  assign y_obs = dut_y;
`endif

  // Raw counter is wider than delay_cyc so TIMEOUT plus the synchronizer latency still fits.
  localparam int               RAW_W     = CNT_W + 2;
  localparam logic [RAW_W-1:0] RAW_LIMIT = RAW_W'(TIMEOUT + COMP);
  localparam logic [RAW_W-1:0] COMP_V    = RAW_W'(COMP);

  state_t           state;
  logic             edge_q;
  logic             ref_y;
  logic [7:0]       settle_cnt;
  logic [RAW_W-1:0] cnt;
  logic [RAW_W-1:0] raw_next;
  logic [CNT_W-1:0] comp_delay;

  assign raw_next   = cnt + RAW_W'(1);
  assign comp_delay = (raw_next > COMP_V) ? CNT_W'(raw_next - COMP_V) : '0;

  always_ff @(posedge C) begin
    if (R) begin
      state      <= S_IDLE;
      dut_a      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      delay_cyc  <= '0;
      timeout    <= 1'b0;
      edge_q     <= 1'b0;
      ref_y      <= 1'b0;
      settle_cnt <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            edge_q <= launch_edge;
            busy   <= 1'b1;
            state  <= S_PRESET;
          end
        end
        S_PRESET: begin
          dut_a      <= ~edge_q;
          settle_cnt <= 8'(SETTLE - 1);
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == 8'd0) begin
            ref_y <= y_obs;
            dut_a <= edge_q;
            cnt   <= '0;
            state <= S_MEASURE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_MEASURE: begin
          // The limit is reached before cnt can grow past it, so it never wraps.
          if (y_obs != ref_y) begin
            delay_cyc <= comp_delay;
            timeout   <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (raw_next == RAW_LIMIT) begin
            delay_cyc <= CNT_W'(TIMEOUT);
            timeout   <= 1'b1;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= raw_next;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
